// File: rtl/barrel_shifter.sv
// rtl/barrel_shifter.sv - logarithmic left/logical-right/arithmetic-right barrel shifter
// Combinational result plus a one-cycle registered copy with valid.
module barrel_shifter #(
   parameter int N = 16,
   parameter int M = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] data,
   input  logic [M-1:0] shamt,
   input  logic         dir,
   input  logic         arith,
   input  logic         in_valid,
   output logic [N-1:0] out,
   output logic [N-1:0] out_q,
   output logic         out_valid
);

   localparam logic [N-1:0] ONES = '1;

   logic         fill;
   logic [N-1:0] net_in;
   logic [N-1:0] net_out;
   logic [N-1:0] out_d;
   logic         valid_d;
   logic         valid_q;

   // Gated by dir so arith can never leak into a left shift.
   assign fill = dir & arith & data[N-1];

   // Right shifts reuse the left network by reversing bits in and out.
   always_comb begin
      net_in = '0;
      for (int i = 0; i < N; i++) begin
         net_in[i] = dir ? data[N-1-i] : data[i];
      end
   end

   always_comb begin
      net_out = net_in;
      for (int k = 0; k < M; k++) begin
         if (shamt[k]) begin
            net_out = (net_out << (1 << k)) | ({N{fill}} & ~(ONES << (1 << k)));
         end
      end
   end

   always_comb begin
      out = '0;
      for (int i = 0; i < N; i++) begin
         out[i] = dir ? net_out[N-1-i] : net_out[i];
      end
   end

   assign out_d   = out;
   assign valid_d = in_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         out_q   <= out_d;
         valid_q <= valid_d;
      end
   end

   assign out_valid = valid_q;

endmodule

// File: tb/tb_barrel_shifter.sv
// tb/tb_barrel_shifter.sv - self-checking bench for barrel_shifter
module tb_barrel_shifter;
   localparam int N = 16;
   localparam int M = 4;

   typedef struct {
      logic [N-1:0] res;
      logic         vld;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] data;
   logic [M-1:0] shamt;
   logic         dir;
   logic         arith;
   logic         in_valid;
   logic [N-1:0] out;
   logic [N-1:0] out_q;
   logic         out_valid;

   int   checks;
   int   failures;
   exp_t sb_q[$];

   barrel_shifter #(.N(N), .M(M)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .data(data),
      .shamt(shamt),
      .dir(dir),
      .arith(arith),
      .in_valid(in_valid),
      .out(out),
      .out_q(out_q),
      .out_valid(out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic logic [N-1:0] ref_shift(input logic [N-1:0] d, input logic [M-1:0] s,
                                              input logic dr, input logic ar);
      logic [N-1:0] r;
      if (!dr)      r = d << s;
      else if (ar)  r = $signed(d) >>> s;
      else          r = d >> s;
      return r;
   endfunction

   task automatic comb_chk(input string tag, input logic [N-1:0] d, input logic [M-1:0] s,
                           input logic dr, input logic ar, input logic [N-1:0] expv);
      data = d; shamt = s; dir = dr; arith = ar; in_valid = 1'b0;
      #1;
      check(tag, out, expv);
   endtask

   // Drive one vector, check comb out, push expectation, compare registered copy next edge.
   task automatic step(input logic [N-1:0] d, input logic [M-1:0] s,
                       input logic dr, input logic ar, input logic v);
      exp_t e;
      exp_t got;
      data = d; shamt = s; dir = dr; arith = ar; in_valid = v;
      #1;
      e.res = ref_shift(d, s, dr, ar);
      e.vld = v;
      check("rand_out", out, e.res);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check("sb_empty", 16'd1, 16'd0);
      end else begin
         got = sb_q.pop_front();
         check("rand_out_q", out_q, got.res);
         check("rand_out_valid", {15'd0, out_valid}, {15'd0, got.vld});
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      data = '0; shamt = '0; dir = 1'b0; arith = 1'b0; in_valid = 1'b0;
      #12;
      check("reset_out_q", out_q, 16'h0000);
      check("reset_out_valid", {15'd0, out_valid}, 16'd0);
      rst_n = 1'b1;

      comb_chk("sh0_l",     16'hA5A5, 4'd0, 1'b0, 1'b0, 16'hA5A5);
      comb_chk("sh0_l_ar",  16'hA5A5, 4'd0, 1'b0, 1'b1, 16'hA5A5);
      comb_chk("sh0_rl",    16'hA5A5, 4'd0, 1'b1, 1'b0, 16'hA5A5);
      comb_chk("sh0_ra",    16'hA5A5, 4'd0, 1'b1, 1'b1, 16'hA5A5);
      comb_chk("sh15_l",    16'hA5A5, 4'd15, 1'b0, 1'b0, 16'h8000);
      comb_chk("sh15_rl",   16'hA5A5, 4'd15, 1'b1, 1'b0, 16'h0001);
      comb_chk("sh15_ra_p", 16'h1A2B, 4'd15, 1'b1, 1'b1, 16'h0000);
      comb_chk("sh15_ra_n", 16'hF0F0, 4'd15, 1'b1, 1'b1, 16'hFFFF);
      comb_chk("sh4_l",     16'hF0F0, 4'd4, 1'b0, 1'b0, 16'h0F00);
      comb_chk("sh4_rl",    16'hF0F0, 4'd4, 1'b1, 1'b0, 16'h0F0F);
      comb_chk("sh4_ra",    16'hF0F0, 4'd4, 1'b1, 1'b1, 16'hFF0F);
      comb_chk("l_arith_ign", 16'h8001, 4'd1, 1'b0, 1'b1, 16'h0002);

      // Registered path and asynchronous reset mid-cycle.
      @(posedge clk);
      #2;
      data = 16'h1234; shamt = 4'd4; dir = 1'b0; arith = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("reg_out_q", out_q, 16'h2340);
      check("reg_out_valid", {15'd0, out_valid}, 16'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_q", out_q, 16'h0000);
      check("arst_out_valid", {15'd0, out_valid}, 16'd0);
      check("arst_out_comb", out, 16'h2340);
      @(posedge clk);
      #1;
      check("held_out_q", out_q, 16'h0000);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("resume_out_q", out_q, 16'h2340);
      check("resume_out_valid", {15'd0, out_valid}, 16'd1);

      step(16'h8000, 4'd15, 1'b1, 1'b1, 1'b1);
      step(16'h8000, 4'd15, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 60; i++) begin
         step(N'($urandom), M'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/barrel_shifter.md
Name: barrel_shifter

Overview:
Parameterised N-bit logarithmic barrel shifter supporting logical left, logical right and arithmetic right shifts. The primary result `out` is purely combinational, so it is valid within the same cycle as its inputs. A registered copy with a valid flag is provided for pipelined consumers on the `clk` domain. The block is a datapath primitive used by ALU/shift units.

Parameters:
N, 16, data width in bits (N >= 2).
M, $clog2(N), shift-amount width; must equal $clog2(N).

Ports:
clk  input  1  system clock; registered path only.
rst_n  input  1  asynchronous, active-low reset.
data  input  N  operand to shift.
shamt  input  M  shift amount, unsigned, 0..2^M-1.
dir  input  1  0 = left shift, 1 = right shift.
arith  input  1  right shifts only: 1 = arithmetic (sign fill), 0 = logical (zero fill).
in_valid  input  1  qualifies inputs for the registered path.
out  output  N  combinational shift result.
out_q  output  N  registered shift result.
out_valid  output  1  registered in_valid.

Behaviour:
- Combinational path, zero latency. `out` is a function of data, shamt, dir and arith only, independent of clk and rst_n:
  - dir=0: out = data << shamt, zero fill; arith is ignored.
  - dir=1, arith=0: out = data >> shamt, zero fill.
  - dir=1, arith=1: out = signed(data) >>> shamt, filled with data[N-1].
- Structure is M mux stages. Stage k shifts by 2^k when shamt[k]=1, otherwise it passes the value through.
  - The fill bit is 0 for left and logical-right shifts, and data[N-1] for arithmetic-right shifts.
  - Right shifts may reuse the left-shift network through bit-reversal of input and output, or use a dedicated network; either is acceptable.
- The result is always exactly N bits. Bits shifted out are discarded and there is no carry or overflow output.
- Boundary conditions:
  - shamt=0: out = data for every dir/arith combination.
  - shamt=N-1 left: out = {data[0], N-1 zeros}.
  - shamt=N-1 logical right: out = {N-1 zeros, data[N-1]}.
  - shamt=N-1 arithmetic right: all bits = data[N-1].
  - If N is not a power of two and shamt >= N: result is all zeros, or all sign bits for an arithmetic-right shift.
- Registered path:
  - On each rising clk edge: out_q <= out and out_valid <= in_valid. out_q updates every cycle regardless of in_valid.
  - Latency is one cycle; throughput is one result per cycle.
- Reset:
  - rst_n=0 asynchronously forces out_q = 0 and out_valid = 0, including when asserted mid-stream.
  - Registers resume capturing on the first rising clk edge after rst_n deasserts.
  - `out` is unaffected by reset and remains valid while rst_n=0.
- No X propagation from unused inputs: arith must not affect the result when dir=0.

Test Plan:
1. data=A5A5, shamt=0, all four dir/arith combinations -> out=A5A5.
2. data=A5A5, shamt=15 -> out=8000 for dir=0; out=0001 for dir=1, arith=0.
3. dir=1, arith=1, shamt=15 -> data=1A2B gives out=0000; data=F0F0 gives out=FFFF.
4. data=F0F0, shamt=4 -> out=0F00 for dir=0; 0F0F for dir=1, arith=0; FF0F for dir=1, arith=1. Also dir=0, arith=1, data=8001, shamt=1 -> out=0002.
5. Registered path: apply data=1234, shamt=4, dir=0, in_valid=1 -> after one clk edge out_q=2340 and out_valid=1. Assert rst_n=0 between clock edges -> out_q=0000 and out_valid=0 immediately, while out still reads 2340.
6. At least 50 random (data, shamt, dir, arith) vectors, settled 10 ns each -> out matches the reference operators <<, >> and $signed >>> bit-exactly (=== compare). out_q matches out delayed by one cycle.
